// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register with valid/ready handshake.
// Builds the ALU control code and selects operand1 for the execute stage.
module id_ex_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  flush,
    input  logic [DATA_W-1:0]     rs_data,
    input  logic [DATA_W-1:0]     rt_data,
    input  logic [15:0]           imm16,
    input  logic                  imm_sext,
    input  logic                  alu_src,
    input  logic [1:0]            alu_op,
    input  logic [5:0]            funct,
    input  logic [REG_ADDR_W-1:0] rd_in,
    input  logic                  reg_write_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     operand0,
    output logic [DATA_W-1:0]     operand1,
    output logic [3:0]            control,
    output logic [REG_ADDR_W-1:0] rd_out,
    output logic                  reg_write_out,
    output logic                  illegal
);

    logic              accept;
    logic [3:0]        ctrl_d;
    logic              illegal_d;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] op1_d;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    assign imm_ext = imm_sext ? {{(DATA_W-16){imm16[15]}}, imm16}
                              : {{(DATA_W-16){1'b0}}, imm16};
    assign op1_d   = alu_src ? imm_ext : rt_data;

    always_comb begin
        ctrl_d    = 4'b0010;
        illegal_d = 1'b0;
        unique case (alu_op)
            2'b00: ctrl_d = 4'b0010;
            2'b01: ctrl_d = 4'b0110;
            2'b11: ctrl_d = 4'b0001;
            2'b10: begin
                case (funct)
                    6'b100000: ctrl_d = 4'b0010;
                    6'b100010: ctrl_d = 4'b0110;
                    6'b100100: ctrl_d = 4'b0000;
                    6'b100101: ctrl_d = 4'b0001;
                    6'b100110: ctrl_d = 4'b0011;
                    6'b100111: ctrl_d = 4'b1100;
                    6'b101010: ctrl_d = 4'b0111;
                    default:   illegal_d = 1'b1;
                endcase
            end
        endcase
    end

    // Flush beats accept; a drained bundle with no replacement clears valid.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid     <= 1'b0;
            operand0      <= '0;
            operand1      <= '0;
            control       <= 4'b0000;
            rd_out        <= '0;
            reg_write_out <= 1'b0;
            illegal       <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid     <= 1'b1;
            operand0      <= rs_data;
            operand1      <= op1_d;
            control       <= ctrl_d;
            rd_out        <= rd_in;
            reg_write_out <= reg_write_in && !illegal_d;
            illegal       <= illegal_d;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: vector table plus scoreboard
// queue, with hand-written stall, flush and reset sequences.
module tb_id_ex_stage;

    typedef struct {
        logic [31:0] rs;
        logic [31:0] rt;
        logic [15:0] imm;
        logic        sext;
        logic        src;
        logic [1:0]  op;
        logic [5:0]  fn;
        logic [4:0]  rd;
        logic        rw;
        logic [31:0] e_op1;
        logic [3:0]  e_ctrl;
        logic        e_ill;
        logic        e_rw;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [15:0] imm16;
    logic        imm_sext;
    logic        alu_src;
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic [4:0]  rd_in;
    logic        reg_write_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] operand0;
    logic [31:0] operand1;
    logic [3:0]  control;
    logic [4:0]  rd_out;
    logic        reg_write_out;
    logic        illegal;

    int   checks = 0;
    int   passes = 0;
    vec_t vecs[14];
    vec_t sb[$];

    id_ex_stage #(.DATA_W(32), .REG_ADDR_W(5)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .rs_data(rs_data), .rt_data(rt_data), .imm16(imm16),
        .imm_sext(imm_sext), .alu_src(alu_src), .alu_op(alu_op),
        .funct(funct), .rd_in(rd_in), .reg_write_in(reg_write_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .operand0(operand0), .operand1(operand1), .control(control),
        .rd_out(rd_out), .reg_write_out(reg_write_out),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: act=%h exp=%h", name, act, exp);
    endtask

    function automatic vec_t mk(
        logic [31:0] rs, logic [31:0] rt, logic [15:0] imm,
        logic sext, logic src, logic [1:0] op, logic [5:0] fn,
        logic [4:0] rd, logic rw, logic [31:0] e_op1,
        logic [3:0] e_ctrl, logic e_ill, logic e_rw);
        vec_t v;
        v.rs = rs; v.rt = rt; v.imm = imm; v.sext = sext;
        v.src = src; v.op = op; v.fn = fn; v.rd = rd; v.rw = rw;
        v.e_op1 = e_op1; v.e_ctrl = e_ctrl;
        v.e_ill = e_ill; v.e_rw = e_rw;
        return v;
    endfunction

    task automatic drive(vec_t v);
        rs_data      = v.rs;
        rt_data      = v.rt;
        imm16        = v.imm;
        imm_sext     = v.sext;
        alu_src      = v.src;
        alu_op       = v.op;
        funct        = v.fn;
        rd_in        = v.rd;
        reg_write_in = v.rw;
    endtask

    // Scoreboard: a bundle transfers at the edge after a negedge
    // where out_valid && out_ready.
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_out", 32'(out_valid), 32'd0);
            end else begin
                vec_t e;
                e = sb.pop_front();
                check("operand0", operand0, e.rs);
                check("operand1", operand1, e.e_op1);
                check("control", 32'(control), 32'(e.e_ctrl));
                check("illegal", 32'(illegal), 32'(e.e_ill));
                check("reg_write_out", 32'(reg_write_out), 32'(e.e_rw));
                check("rd_out", 32'(rd_out), 32'(e.rd));
            end
        end
    end

    initial begin
        vec_t a;
        vec_t b;
        vecs[0]  = mk(32'hffffff68, 32'hffffff34, 16'h0000, 0, 0, 2'b10,
                      6'b100000, 5'd3, 1, 32'hffffff34, 4'b0010, 0, 1);
        vecs[1]  = mk(32'h00000010, 32'h12345678, 16'hff34, 1, 1, 2'b00,
                      6'b000000, 5'd4, 1, 32'hffffff34, 4'b0010, 0, 1);
        vecs[2]  = mk(32'h00000010, 32'h12345678, 16'hff34, 0, 1, 2'b00,
                      6'b000000, 5'd5, 1, 32'h0000ff34, 4'b0010, 0, 1);
        vecs[3]  = mk(32'h0000000a, 32'h0000000b, 16'h7fff, 1, 1, 2'b01,
                      6'b000000, 5'd6, 1, 32'h00007fff, 4'b0110, 0, 1);
        vecs[4]  = mk(32'h00000001, 32'h00000002, 16'h8000, 0, 1, 2'b11,
                      6'b000000, 5'd7, 1, 32'h00008000, 4'b0001, 0, 1);
        vecs[5]  = mk(32'h11111111, 32'h22222222, 16'h0000, 0, 0, 2'b10,
                      6'b100010, 5'd8, 1, 32'h22222222, 4'b0110, 0, 1);
        vecs[6]  = mk(32'h33333333, 32'h44444444, 16'h0000, 0, 0, 2'b10,
                      6'b100100, 5'd9, 1, 32'h44444444, 4'b0000, 0, 1);
        vecs[7]  = mk(32'h55555555, 32'h66666666, 16'h0000, 0, 0, 2'b10,
                      6'b100101, 5'd10, 0, 32'h66666666, 4'b0001, 0, 0);
        vecs[8]  = mk(32'h77777777, 32'h88888888, 16'h0000, 0, 0, 2'b10,
                      6'b100110, 5'd11, 1, 32'h88888888, 4'b0011, 0, 1);
        vecs[9]  = mk(32'h99999999, 32'haaaaaaaa, 16'h0000, 0, 0, 2'b10,
                      6'b100111, 5'd12, 1, 32'haaaaaaaa, 4'b1100, 0, 1);
        vecs[10] = mk(32'hbbbbbbbb, 32'hcccccccc, 16'h0000, 0, 0, 2'b10,
                      6'b101010, 5'd13, 1, 32'hcccccccc, 4'b0111, 0, 1);
        vecs[11] = mk(32'hdddddddd, 32'heeeeeeee, 16'h1234, 1, 0, 2'b10,
                      6'b111111, 5'd14, 1, 32'heeeeeeee, 4'b0010, 1, 0);
        vecs[12] = mk(32'h01020304, 32'h05060708, 16'h0000, 0, 0, 2'b01,
                      6'b111111, 5'd15, 1, 32'h05060708, 4'b0110, 0, 1);
        vecs[13] = mk(32'hcafef00d, 32'h0badbeef, 16'h8000, 1, 1, 2'b11,
                      6'b000000, 5'd31, 1, 32'hffff8000, 4'b0001, 0, 1);

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(vecs[0]);

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_control", 32'(control), 32'd0);
        check("rst_operand0", operand0, 32'd0);
        check("rst_operand1", operand1, 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        reset_n   = 1'b1;
        out_ready = 1'b1;

        // Back-to-back stream through the vector table.
        foreach (vecs[i]) begin
            drive(vecs[i]);
            in_valid = 1'b1;
            sb.push_back(vecs[i]);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("stream_drained", 32'(sb.size()), 32'd0);
        check("idle_out_valid", 32'(out_valid), 32'd0);

        // Stall: hold A while B waits at the input.
        a = vecs[9];
        b = vecs[11];
        out_ready = 1'b0;
        drive(a);
        in_valid = 1'b1;
        sb.push_back(a);
        @(posedge clk);
        #1;
        drive(b);
        for (int c = 0; c < 3; c++) begin
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_operand0", operand0, a.rs);
            check("stall_operand1", operand1, a.e_op1);
            check("stall_control", 32'(control), 32'(a.e_ctrl));
            check("stall_rd_out", 32'(rd_out), 32'(a.rd));
            @(posedge clk);
            #1;
        end
        sb.push_back(b);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("post_stall_control", 32'(control), 32'(b.e_ctrl));
        check("post_stall_illegal", 32'(illegal), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        check("stall_drained", 32'(sb.size()), 32'd0);

        // Flush together with an incoming bundle: nothing emitted.
        drive(vecs[0]);
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check("flush_in_out_valid", 32'(out_valid), 32'd0);
            @(posedge clk);
            #1;
        end

        // Flush of a held bundle.
        out_ready = 1'b0;
        drive(vecs[4]);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("held_out_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_held_valid", 32'(out_valid), 32'd0);

        // Reset while a bundle is held.
        drive(vecs[13]);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_control", 32'(control), 32'd0);
        check("mid_rst_operand1", operand1, 32'd0);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
